spi_slave_stream: RTL and testbench
===================================

Name: spi_slave_stream

Overview:
- Parametrised SPI slave, successor to the fixed 8-bit slave. It oversamples sclk, cs and mosi on sys_clk.
- Supports any word width and MSB- or LSB-first order. SPI mode (CPOL/CPHA) is selectable at run time.
- Supports back-to-back multi-word frames under one cs assertion.
- Sits between the MCU SPI pins and the FPGA register/stream logic. It exposes a valid/ready tx interface and a valid-pulse rx interface.

Parameters:
- DATA_W, 8, bits per word (4..32).
- SYNC_STAGES, 2, synchroniser flops on cs_n, sclk and mosi (2..3).
- LSB_FIRST, 0, 1 = shift bit 0 first; 0 = MSB first.

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- cfg_cpol  in  1  clock idle level; latched at frame start.
- cfg_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at frame start.
- cs_n  in  1  chip select, active low, asynchronous.
- sclk  in  1  SPI clock, asynchronous.
- mosi  in  1  master-out data, asynchronous.
- miso  out  1  slave-out data.
- miso_oe  out  1  tri-state enable for the miso pad.
- tx_data  in  DATA_W  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  one-cycle pulse: tx_data consumed this cycle.
- rx_data  out  DATA_W  last received word; held until the next word completes.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- tx_underrun  out  1  one-cycle pulse: word load found tx_valid=0, so zeros are sent.
- frame_abort  out  1  one-cycle pulse: cs_n rose with a partial word.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset values: all outputs are 0, the FSM is in IDLE, all counters and shift registers are 0. Reset is allowed mid-frame and abandons the frame with no pulses.
- Input synchronisation: cs_n, sclk and mosi each pass through SYNC_STAGES flops. Edges are detected from the last synchronised stage against one extra delay flop.
- Edge definitions:
  - Leading edge = transition away from the latched cpol.
  - Trailing edge = transition back to cpol.
  - Sample edge = leading if cpha=0, else trailing.
  - Shift edge = the other edge.
- Timing requirement: sclk high time and low time must each be at least SYNC_STAGES+2 sys_clk cycles.
- FSM states: IDLE, LOAD, SHIFT, WORD_END.
- IDLE:
  - On synchronised cs_n falling: latch cpol/cpha, clear the bit counter, go to LOAD.
  - miso_oe=0.
- LOAD (one cycle):
  - If tx_valid=1: tx_shift<=tx_data and tx_ready pulses.
  - Else: tx_shift<=0 and tx_underrun pulses.
  - miso_oe<=1. Go to SHIFT.
- miso timing:
  - cpha=0: the first bit of the word is driven on miso in the cycle after LOAD.
  - cpha=1: miso is updated at each shift edge, so the first bit appears at the first leading edge.
- SHIFT:
  - On each sample edge: rx_shift takes mosi, inserted at the end selected by LSB_FIRST, and the bit counter increments.
  - On each shift edge: advance to the next tx bit.
  - When the counter reaches DATA_W, go to WORD_END.
- WORD_END (one cycle):
  - rx_data<=rx_shift; rx_valid pulses; the bit counter is cleared.
  - Go to LOAD while cs_n is still low, so the next word is reloaded with no gap.
  - For cpha=0, bit 0 of the new word is driven at the trailing edge that follows the previous word's last sample edge.
- cs_n rising (synchronised) in any non-IDLE state:
  - Go to IDLE and set miso_oe<=0.
  - If 0 < bit counter < DATA_W, frame_abort pulses and rx_data is unchanged.
  - A cs_n rise takes priority over any sclk edge in the same cycle.
  - A rise during WORD_END still completes that word (rx_valid pulses), then the FSM goes to IDLE.
- sclk edges seen while in IDLE or LOAD are ignored.
- cfg_cpol/cfg_cpha changes take effect only at the next frame start.
- Counter width: $clog2(DATA_W+1). It never wraps within a word.
- Latency: cs_n falling to tx_ready is SYNC_STAGES+2 cycles.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE/LOAD/SHIFT/WORD_END);
  - mode encoding constants SPI_MODE0..3 = {cpol,cpha};
  - the default DATA_W and SYNC_STAGES.
- Sub-module spi_sync_edge (parameter SYNC_STAGES):
  - Input: one asynchronous signal. Outputs: synchronised level, rise pulse, fall pulse.
  - Instanced for cs_n, sclk and mosi; only the level output is used for mosi.

Test Plan:
1. Mode 0, DATA_W=8, tx_data=0xA5 valid, master sends 0x3C in one word -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; one rx_valid pulse; one tx_ready pulse.
2. Mode 3, same data -> identical rx/tx results with sampling on rising sclk; miso_oe=0 after cs_n rises.
3. Two-word frame, mode 1, tx words 0x12 then 0x34 supplied back-to-back -> rx_valid pulses twice; miso carries 0x12 then 0x34 with no gap; tx_ready pulses twice.
4. tx_valid=0 at frame start -> tx_underrun pulses; miso sends 0x00; rx still captures the master byte 0xFF.
5. cs_n rises after 5 sample edges -> frame_abort pulses, no rx_valid, rx_data keeps its previous value, busy=0 within SYNC_STAGES+1 cycles.
6. LSB_FIRST=1, DATA_W=16, master sends 0xBEEF LSB-first -> rx_data=0xBEEF. A reset asserted at bit 9 of the next frame -> all outputs are 0, and the next frame works normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the parametrised SPI slave.
// Mode constants are {cpol, cpha}.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    SHIFT    = 2'd2,
    WORD_END = 2'd3
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchroniser for one asynchronous pin.
// Produces a level plus single-cycle rise/fall pulses from the last stage.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign fall  = ~sync_q[SYNC_STAGES-1] & dly_q;

endmodule

// File: rtl/spi_slave_stream.sv
// Oversampling SPI slave with run-time CPOL/CPHA, any word width and
// back-to-back words under one chip select; valid/ready tx, pulsed rx.
module spi_slave_stream
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter bit LSB_FIRST   = 1'b0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cs_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort,
  output logic              busy
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

  logic cs_lvl_unused, cs_rise, cs_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .async_in(cs_n),
    .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .async_in(sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .async_in(mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_abort_q, frame_abort_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;

  logic              leading, trailing, sample_edge, shift_edge;
  logic [DATA_W-1:0] load_word, rx_insert;

  function automatic logic out_bit(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  always_comb begin
    leading     = cpol_q ? sclk_fall : sclk_rise;
    trailing    = cpol_q ? sclk_rise : sclk_fall;
    sample_edge = cpha_q ? trailing : leading;
    shift_edge  = cpha_q ? leading : trailing;
    load_word   = tx_valid ? tx_data : '0;
    rx_insert   = LSB_FIRST ? {mosi_s, rx_shift_q[DATA_W-1:1]}
                            : {rx_shift_q[DATA_W-2:0], mosi_s};
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    first_d       = first_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_abort_d = 1'b0;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    tx_ready      = 1'b0;
    tx_underrun   = 1'b0;

    // A chip-select release outranks any sclk edge seen in the same cycle.
    if (cs_rise && state_q != IDLE) begin
      state_d   = IDLE;
      cnt_d     = '0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      if (cnt_q != '0 && cnt_q < CNT_FULL) frame_abort_d = 1'b1;
      if (state_q == WORD_END) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          miso_oe_d = 1'b0;
          if (cs_fall) begin
            cpol_d  = cfg_cpol;
            cpha_d  = cfg_cpha;
            cnt_d   = '0;
            first_d = 1'b1;
            state_d = LOAD;
          end
        end
        LOAD: begin
          tx_ready    = tx_valid;
          tx_underrun = ~tx_valid;
          miso_oe_d   = 1'b1;
          // With cpha=0 only the first word is pre-driven; later words get
          // their first bit from the trailing edge closing the previous word.
          if (!cpha_q && first_q) begin
            miso_d     = out_bit(load_word);
            tx_shift_d = advance(load_word);
          end else begin
            tx_shift_d = load_word;
          end
          state_d = SHIFT;
        end
        SHIFT: begin
          if (sample_edge) begin
            rx_shift_d = rx_insert;
            cnt_d      = cnt_q + CNT_W'(1);
            if (cnt_q + CNT_W'(1) == CNT_FULL) state_d = WORD_END;
          end else if (shift_edge) begin
            miso_d     = out_bit(tx_shift_q);
            tx_shift_d = advance(tx_shift_q);
          end
        end
        WORD_END: begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          cnt_d      = '0;
          first_d    = 1'b0;
          state_d    = LOAD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      first_q       <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_abort_q <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      first_q       <= first_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_abort_q <= frame_abort_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_abort = frame_abort_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench: an 8-bit MSB-first slave and a 16-bit LSB-first slave
// share sclk/mosi; each has its own chip select.
module tb_spi_slave_stream;
  import spi_pkg::*;

  localparam int HALF = 8;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic cfg_cpol = 1'b0, cfg_cpha = 1'b0;
  logic cs8_n = 1'b1, cs16_n = 1'b1, sclk = 1'b0, mosi = 1'b0;

  logic        miso8, oe8, tx8_valid = 1'b0, tx8_ready, rx8_valid, und8, abt8, busy8;
  logic [7:0]  tx8_data = 8'h00, rx8_data;
  logic        miso16, oe16, tx16_valid = 1'b0, tx16_ready, rx16_valid, und16, abt16, busy16;
  logic [15:0] tx16_data = 16'h0000, rx16_data;

  int n_checks = 0;
  int n_pass   = 0;

  int n_rx8 = 0, n_txr8 = 0, n_und8 = 0, n_abt8 = 0, n_rx16 = 0;
  logic [15:0] rx8_hist = 16'h0000;

  always #5 sys_clk = ~sys_clk;

  spi_slave_stream #(.DATA_W(8), .SYNC_STAGES(2), .LSB_FIRST(1'b0)) u_dut8 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cs_n(cs8_n), .sclk(sclk), .mosi(mosi), .miso(miso8), .miso_oe(oe8),
    .tx_data(tx8_data), .tx_valid(tx8_valid), .tx_ready(tx8_ready),
    .rx_data(rx8_data), .rx_valid(rx8_valid), .tx_underrun(und8),
    .frame_abort(abt8), .busy(busy8)
  );

  spi_slave_stream #(.DATA_W(16), .SYNC_STAGES(2), .LSB_FIRST(1'b1)) u_dut16 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cs_n(cs16_n), .sclk(sclk), .mosi(mosi), .miso(miso16), .miso_oe(oe16),
    .tx_data(tx16_data), .tx_valid(tx16_valid), .tx_ready(tx16_ready),
    .rx_data(rx16_data), .rx_valid(rx16_valid), .tx_underrun(und16),
    .frame_abort(abt16), .busy(busy16)
  );

  // Pulse counters sampled mid-cycle; tests compare before/after snapshots.
  always @(negedge sys_clk) begin
    if (rx8_valid) begin
      n_rx8    <= n_rx8 + 1;
      rx8_hist <= {rx8_hist[7:0], rx8_data};
    end
    if (tx8_ready) n_txr8 <= n_txr8 + 1;
    if (und8)      n_und8 <= n_und8 + 1;
    if (abt8)      n_abt8 <= n_abt8 + 1;
    if (rx16_valid) n_rx16 <= n_rx16 + 1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Bit k of the stream lives at word (k / wbits), 16-bit stride, in order.
  function automatic int bidx(input int k, input int wbits, input bit lsb);
    int w, i;
    w = k / wbits;
    i = k % wbits;
    return w * 16 + (lsb ? i : wbits - 1 - i);
  endfunction

  task automatic spi_master(input bit sel, input logic [1:0] mode, input int total_bits,
                            input int wbits, input bit lsb, input logic [63:0] mo,
                            output logic [63:0] mi, output logic oe_all, input bit end_frame);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    cfg_cpol = cpol;
    cfg_cpha = cpha;
    sclk = cpol;
    mosi = 1'b0;
    mi = '0;
    oe_all = 1'b1;
    wait_clks(4);
    if (sel) cs16_n = 1'b0; else cs8_n = 1'b0;
    wait_clks(HALF);
    if (!cpha) mosi = mo[bidx(0, wbits, lsb)];
    for (int k = 0; k < total_bits; k++) begin
      if (cpha) mosi = mo[bidx(k, wbits, lsb)];
      sclk = ~cpol;
      if (!cpha) begin
        mi[bidx(k, wbits, lsb)] = sel ? miso16 : miso8;
        oe_all = oe_all & (sel ? oe16 : oe8);
      end
      wait_clks(HALF);
      sclk = cpol;
      if (cpha) begin
        mi[bidx(k, wbits, lsb)] = sel ? miso16 : miso8;
        oe_all = oe_all & (sel ? oe16 : oe8);
      end else if (k + 1 < total_bits) begin
        mosi = mo[bidx(k + 1, wbits, lsb)];
      end
      wait_clks(HALF);
    end
    if (end_frame) begin
      if (sel) cs16_n = 1'b1; else cs8_n = 1'b1;
      wait_clks(2 * HALF);
    end
  endtask

  task automatic tx_feed(input bit sel, input int n, input logic [31:0] words);
    logic got;
    for (int w = 0; w < n; w++) begin
      if (sel) begin tx16_data = words[w*16 +: 16]; tx16_valid = 1'b1; end
      else     begin tx8_data  = words[w*16 +: 8];  tx8_valid  = 1'b1; end
      got = 1'b0;
      for (int c = 0; c < 4000 && !got; c++) begin
        @(negedge sys_clk);
        got = sel ? tx16_ready : tx8_ready;
      end
      if (!got) begin
        n_checks++;
        $display("FAIL tx_feed_timeout: word %0d tx_ready=0, required 1", w);
      end
      @(posedge sys_clk);
      #1;
    end
    tx8_valid  = 1'b0;
    tx16_valid = 1'b0;
  endtask

  task automatic test_reset;
    wait_clks(3);
    n_checks++; if ({miso8, oe8, rx8_valid, tx8_ready, und8, abt8, busy8} !== 7'b0)
      $display("FAIL reset_ctl8: got %b required 0000000", {miso8, oe8, rx8_valid, tx8_ready, und8, abt8, busy8}); else n_pass++;
    n_checks++; if (rx8_data !== 8'h00) $display("FAIL reset_rx8: got %h required 00", rx8_data); else n_pass++;
    n_checks++; if ({miso16, oe16, rx16_valid, tx16_ready, und16, abt16, busy16} !== 7'b0)
      $display("FAIL reset_ctl16: got %b required 0000000", {miso16, oe16, rx16_valid, tx16_ready, und16, abt16, busy16}); else n_pass++;
    n_checks++; if (rx16_data !== 16'h0000) $display("FAIL reset_rx16: got %h required 0000", rx16_data); else n_pass++;
    sys_rst_n = 1'b1;
    wait_clks(4);
    $display("reset: done");
  endtask

  task automatic test_mode0_single;
    logic [63:0] mi;
    logic oe_all;
    int lat, rx0, txr0;
    rx0 = n_rx8; txr0 = n_txr8; lat = -1;
    fork
      spi_master(1'b0, SPI_MODE0, 8, 8, 1'b0, 64'h3C, mi, oe_all, 1'b1);
      tx_feed(1'b0, 1, 32'h00A5);
      begin
        @(negedge cs8_n);
        for (int i = 0; i < 40; i++) begin
          @(negedge sys_clk);
          if (tx8_ready) begin lat = i + 1; break; end
        end
      end
    join
    wait_clks(2);
    n_checks++; if (lat !== 4) $display("FAIL m0_latency: got %0d required 4", lat); else n_pass++;
    n_checks++; if (mi[7:0] !== 8'hA5) $display("FAIL m0_miso: got %h required a5", mi[7:0]); else n_pass++;
    n_checks++; if (rx8_data !== 8'h3C) $display("FAIL m0_rx: got %h required 3c", rx8_data); else n_pass++;
    n_checks++; if (n_rx8 - rx0 !== 1) $display("FAIL m0_rx_valid: got %0d pulses required 1", n_rx8 - rx0); else n_pass++;
    n_checks++; if (n_txr8 - txr0 !== 1) $display("FAIL m0_tx_ready: got %0d pulses required 1", n_txr8 - txr0); else n_pass++;
    n_checks++; if (oe_all !== 1'b1) $display("FAIL m0_oe: got %b required 1", oe_all); else n_pass++;
    $display("mode0 single: miso=%h rx=%h latency=%0d", mi[7:0], rx8_data, lat);
  endtask

  task automatic test_mode3_single;
    logic [63:0] mi;
    logic oe_all;
    int rx0, txr0;
    rx0 = n_rx8; txr0 = n_txr8;
    fork
      spi_master(1'b0, SPI_MODE3, 8, 8, 1'b0, 64'h3C, mi, oe_all, 1'b1);
      tx_feed(1'b0, 1, 32'h00A5);
    join
    wait_clks(2);
    n_checks++; if (mi[7:0] !== 8'hA5) $display("FAIL m3_miso: got %h required a5", mi[7:0]); else n_pass++;
    n_checks++; if (rx8_data !== 8'h3C) $display("FAIL m3_rx: got %h required 3c", rx8_data); else n_pass++;
    n_checks++; if (n_rx8 - rx0 !== 1) $display("FAIL m3_rx_valid: got %0d pulses required 1", n_rx8 - rx0); else n_pass++;
    n_checks++; if (n_txr8 - txr0 !== 1) $display("FAIL m3_tx_ready: got %0d pulses required 1", n_txr8 - txr0); else n_pass++;
    n_checks++; if (oe8 !== 1'b0) $display("FAIL m3_oe_after_cs: got %b required 0", oe8); else n_pass++;
    $display("mode3 single: miso=%h rx=%h oe=%b", mi[7:0], rx8_data, oe8);
  endtask

  task automatic test_back_to_back;
    logic [63:0] mi;
    logic oe_all;
    int rx0, txr0;
    rx0 = n_rx8; txr0 = n_txr8;
    fork
      spi_master(1'b0, SPI_MODE1, 16, 8, 1'b0, {32'h0, 16'h005B, 16'h00A1}, mi, oe_all, 1'b1);
      tx_feed(1'b0, 2, {16'h0034, 16'h0012});
    join
    wait_clks(2);
    n_checks++; if ({mi[23:16], mi[7:0]} !== 16'h3412) $display("FAIL b2b_miso: got %h required 3412", {mi[23:16], mi[7:0]}); else n_pass++;
    n_checks++; if (rx8_hist !== 16'hA15B) $display("FAIL b2b_rx_words: got %h required a15b", rx8_hist); else n_pass++;
    n_checks++; if (n_rx8 - rx0 !== 2) $display("FAIL b2b_rx_valid: got %0d pulses required 2", n_rx8 - rx0); else n_pass++;
    n_checks++; if (n_txr8 - txr0 !== 2) $display("FAIL b2b_tx_ready: got %0d pulses required 2", n_txr8 - txr0); else n_pass++;
    n_checks++; if (oe_all !== 1'b1) $display("FAIL b2b_oe: got %b required 1", oe_all); else n_pass++;
    $display("back to back: miso=%h,%h rx=%h", mi[7:0], mi[23:16], rx8_hist);
  endtask

  task automatic test_underrun;
    logic [63:0] mi;
    logic oe_all;
    int und0, txr0;
    und0 = n_und8; txr0 = n_txr8;
    tx8_data = 8'hC3;
    spi_master(1'b0, SPI_MODE0, 8, 8, 1'b0, 64'hFF, mi, oe_all, 1'b1);
    wait_clks(2);
    n_checks++; if (n_und8 - und0 == 0) $display("FAIL und_pulse: got 0 pulses required at least 1"); else n_pass++;
    n_checks++; if (mi[7:0] !== 8'h00) $display("FAIL und_miso: got %h required 00", mi[7:0]); else n_pass++;
    n_checks++; if (rx8_data !== 8'hFF) $display("FAIL und_rx: got %h required ff", rx8_data); else n_pass++;
    n_checks++; if (n_txr8 - txr0 !== 0) $display("FAIL und_tx_ready: got %0d pulses required 0", n_txr8 - txr0); else n_pass++;
    $display("underrun: miso=%h rx=%h", mi[7:0], rx8_data);
  endtask

  task automatic test_abort;
    logic [63:0] mi;
    logic oe_all;
    int rx0, abt0;
    rx0 = n_rx8; abt0 = n_abt8;
    fork
      spi_master(1'b0, SPI_MODE0, 5, 8, 1'b0, 64'h55, mi, oe_all, 1'b0);
      tx_feed(1'b0, 1, 32'h0077);
    join
    n_checks++; if (busy8 !== 1'b1) $display("FAIL abort_busy_before: got %b required 1", busy8); else n_pass++;
    cs8_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    n_checks++; if (busy8 !== 1'b0) $display("FAIL abort_busy_after: got %b required 0", busy8); else n_pass++;
    wait_clks(4);
    n_checks++; if (n_abt8 - abt0 !== 1) $display("FAIL abort_pulse: got %0d pulses required 1", n_abt8 - abt0); else n_pass++;
    n_checks++; if (n_rx8 - rx0 !== 0) $display("FAIL abort_rx_valid: got %0d pulses required 0", n_rx8 - rx0); else n_pass++;
    n_checks++; if (rx8_data !== 8'hFF) $display("FAIL abort_rx_hold: got %h required ff", rx8_data); else n_pass++;
    $display("abort: rx=%h busy=%b", rx8_data, busy8);
  endtask

  task automatic test_lsb16_and_reset;
    logic [63:0] mi;
    logic oe_all;
    int rx0;
    rx0 = n_rx16;
    fork
      spi_master(1'b1, SPI_MODE0, 16, 16, 1'b1, 64'hBEEF, mi, oe_all, 1'b1);
      tx_feed(1'b1, 1, 32'h1234);
    join
    wait_clks(2);
    n_checks++; if (rx16_data !== 16'hBEEF) $display("FAIL lsb_rx: got %h required beef", rx16_data); else n_pass++;
    n_checks++; if (mi[15:0] !== 16'h1234) $display("FAIL lsb_miso: got %h required 1234", mi[15:0]); else n_pass++;
    n_checks++; if (n_rx16 - rx0 !== 1) $display("FAIL lsb_rx_valid: got %0d pulses required 1", n_rx16 - rx0); else n_pass++;
    $display("lsb16: miso=%h rx=%h", mi[15:0], rx16_data);

    fork
      spi_master(1'b1, SPI_MODE0, 9, 16, 1'b1, 64'h1357, mi, oe_all, 1'b0);
      tx_feed(1'b1, 1, 32'h0F0F);
    join
    sys_rst_n = 1'b0;
    #2;
    n_checks++; if ({miso16, oe16, rx16_valid, tx16_ready, und16, abt16, busy16} !== 7'b0)
      $display("FAIL midreset_ctl16: got %b required 0000000", {miso16, oe16, rx16_valid, tx16_ready, und16, abt16, busy16}); else n_pass++;
    n_checks++; if (rx16_data !== 16'h0000) $display("FAIL midreset_rx16: got %h required 0000", rx16_data); else n_pass++;
    cs16_n = 1'b1;
    sclk = 1'b0;
    wait_clks(4);
    sys_rst_n = 1'b1;
    wait_clks(4);
    fork
      spi_master(1'b1, SPI_MODE0, 16, 16, 1'b1, 64'hCAFE, mi, oe_all, 1'b1);
      tx_feed(1'b1, 1, 32'h5A5A);
    join
    wait_clks(2);
    n_checks++; if (rx16_data !== 16'hCAFE) $display("FAIL postreset_rx: got %h required cafe", rx16_data); else n_pass++;
    n_checks++; if (mi[15:0] !== 16'h5A5A) $display("FAIL postreset_miso: got %h required 5a5a", mi[15:0]); else n_pass++;
    $display("reset mid-frame then frame: miso=%h rx=%h", mi[15:0], rx16_data);
  endtask

  initial begin
    test_reset;
    test_mode0_single;
    test_mode3_single;
    test_back_to_back;
    test_underrun;
    test_abort;
    test_lsb16_and_reset;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
